// File: rtl/peak_pkg.sv
// Shared definitions for the band peak picker: band count, band edges,
// bin width and FSM state encoding.
package peak_pkg;

  localparam int NUM_BANDS = 6;
  localparam int BIN_W     = 9;
  localparam int EDGE_W    = 10;

  // Half-open band edges; band b covers [BAND_EDGE[b], BAND_EDGE[b+1]).
  localparam logic [NUM_BANDS:0][EDGE_W-1:0] BAND_EDGE = {
    10'd512, 10'd160, 10'd80, 10'd40, 10'd20, 10'd10, 10'd1
  };

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Lower edge of a band, used when a band never saw a non-zero magnitude.
  function automatic logic [BIN_W-1:0] band_low_bin(input logic [2:0] band);
    return BAND_EDGE[band][BIN_W-1:0];
  endfunction

endpackage

// File: rtl/band_decode.sv
// Combinational bin -> band lookup against the shared band edges.
// Bins outside every band (DC and >= 512) report in_band_o = 0.
module band_decode
  import peak_pkg::*;
#(
  parameter int IDX_W = 11
) (
  input  logic [IDX_W-1:0] bin_i,
  output logic             in_band_o,
  output logic [2:0]       band_o
);

  // Find the band whose half-open range contains the bin.
  always_comb begin
    in_band_o = 1'b0;
    band_o    = 3'd0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if ((bin_i >= IDX_W'(BAND_EDGE[b])) && (bin_i < IDX_W'(BAND_EDGE[b+1]))) begin
        in_band_o = 1'b1;
        band_o    = 3'(b);
      end else begin
        in_band_o = in_band_o;
      end
    end
  end

endmodule

// File: rtl/band_peak_picker.sv
// Spectral band peak picker: sweeps bins 0..LAST_IDX through the magnitude
// stage, tracks the per-band maximum of bins 1..511, then emits one record
// per band over a valid/ready stream.
// Optional feature macro: PEAK_THRESHOLD_EN (skip bands whose max < MIN_MAG).
module band_peak_picker
  import peak_pkg::*;
#(
  parameter int               MAG_W    = 16,
  parameter int               IDX_W    = 11,
  parameter int               LAST_IDX = 1023,
  parameter logic [MAG_W-1:0] MIN_MAG  = 16'd64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MAG_W-1:0] mag_i,
  input  logic             mag_valid_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             peak_valid_o,
  input  logic             peak_ready_i,
  output logic [2:0]       peak_band_o,
  output logic [BIN_W-1:0] peak_bin_o,
  output logic [MAG_W-1:0] peak_mag_o,
  output logic             frame_done_o,
  output logic             overrun_o
);

  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(LAST_IDX);
  localparam logic [IDX_W-1:0] ONE_C      = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] band_max_q [NUM_BANDS];
  logic [MAG_W-1:0] band_max_d [NUM_BANDS];
  logic [BIN_W-1:0] band_bin_q [NUM_BANDS];
  logic [BIN_W-1:0] band_bin_d [NUM_BANDS];
  logic             peak_valid_q, peak_valid_d;
  logic [2:0]       peak_band_q, peak_band_d;
  logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;

  logic             in_band;
  logic [2:0]       band;
  logic [NUM_BANDS-1:0] band_ok;
  logic [3:0]       sel_start;
  logic             sel_found;
  logic [2:0]       sel_band;
  logic [BIN_W-1:0] sel_bin;
  logic [MAG_W-1:0] sel_mag;

  band_decode #(.IDX_W(IDX_W)) u_band_decode (
    .bin_i     (cnt_q),
    .in_band_o (in_band),
    .band_o    (band)
  );

  // Request index: look one bin ahead while a sample is being accepted.
  always_comb begin
    if (reset) begin
      idx_o = {IDX_W{1'b0}};
    end else if ((state_q == SCAN) && mag_valid_i) begin
      idx_o = cnt_q + ONE_C;
    end else begin
      idx_o = cnt_q;
    end
  end

  // Pick the next band to present. The sample at LAST_IDX is never inside a
  // band, so the registered maxima are already final when EMIT is entered.
  always_comb begin
    if (state_q == SCAN) begin
      sel_start = 4'd0;
    end else begin
      sel_start = {1'b0, peak_band_q} + 4'd1;
    end
    sel_found = 1'b0;
    sel_band  = 3'd0;
    for (int b = 0; b < NUM_BANDS; b++) begin
`ifdef PEAK_THRESHOLD_EN
      band_ok[b] = (band_max_q[b] >= MIN_MAG);
`else
      band_ok[b] = 1'b1;
`endif
      if (!sel_found && (4'(b) >= sel_start) && band_ok[b]) begin
        sel_found = 1'b1;
        sel_band  = 3'(b);
      end else begin
        sel_found = sel_found;
      end
    end
    sel_mag = band_max_q[sel_band];
    if (sel_mag == {MAG_W{1'b0}}) begin
      sel_bin = band_low_bin(sel_band);
    end else begin
      sel_bin = band_bin_q[sel_band];
    end
  end

  // Next-state logic: scan accumulation, emit sequencing and frame wrap-up.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    band_max_d   = band_max_q;
    band_bin_d   = band_bin_q;
    peak_valid_d = peak_valid_q;
    peak_band_d  = peak_band_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      SCAN: begin
        if (mag_valid_i) begin
          // Strict compare keeps the lowest bin on ties.
          if (in_band && (mag_i > band_max_q[band])) begin
            band_max_d[band] = mag_i;
            band_bin_d[band] = cnt_q[BIN_W-1:0];
          end else begin
            band_max_d[band] = band_max_q[band];
          end
          if (cnt_q == LAST_IDX_C) begin
            cnt_d        = {IDX_W{1'b0}};
            state_d      = EMIT;
            peak_valid_d = sel_found;
            peak_band_d  = sel_found ? sel_band : 3'd0;
            peak_bin_d   = sel_found ? sel_bin : {BIN_W{1'b0}};
            peak_mag_d   = sel_found ? sel_mag : {MAG_W{1'b0}};
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      EMIT: begin
        // Samples arriving while emitting are dropped and flagged.
        if (mag_valid_i) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (peak_valid_q && peak_ready_i && sel_found) begin
          peak_band_d = sel_band;
          peak_bin_d  = sel_bin;
          peak_mag_d  = sel_mag;
        end else if ((peak_valid_q && peak_ready_i) || !peak_valid_q) begin
          peak_valid_d = 1'b0;
          peak_band_d  = 3'd0;
          peak_bin_d   = {BIN_W{1'b0}};
          peak_mag_d   = {MAG_W{1'b0}};
          frame_done_d = 1'b1;
          state_d      = SCAN;
          for (int b = 0; b < NUM_BANDS; b++) begin
            band_max_d[b] = {MAG_W{1'b0}};
            band_bin_d[b] = {BIN_W{1'b0}};
          end
        end else begin
          peak_valid_d = peak_valid_q;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCAN;
      cnt_q        <= {IDX_W{1'b0}};
      peak_valid_q <= 1'b0;
      peak_band_q  <= 3'd0;
      peak_bin_q   <= {BIN_W{1'b0}};
      peak_mag_q   <= {MAG_W{1'b0}};
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        band_max_q[b] <= {MAG_W{1'b0}};
        band_bin_q[b] <= {BIN_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      peak_valid_q <= peak_valid_d;
      peak_band_q  <= peak_band_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      for (int b = 0; b < NUM_BANDS; b++) begin
        band_max_q[b] <= band_max_d[b];
        band_bin_q[b] <= band_bin_d[b];
      end
    end
  end

  assign peak_valid_o = peak_valid_q;
  assign peak_band_o  = peak_band_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_mag_o   = peak_mag_q;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_band_peak_picker.sv
// Scoreboard bench for band_peak_picker: stimulus pushes hand-computed
// records into a queue; a negedge monitor pops and compares on handshakes.
module tb_band_peak_picker;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mag_i;
  logic        mag_valid_i;
  logic [10:0] idx_o;
  logic        peak_valid_o;
  logic        peak_ready_i;
  logic [2:0]  peak_band_o;
  logic [8:0]  peak_bin_o;
  logic [15:0] peak_mag_o;
  logic        frame_done_o;
  logic        overrun_o;

  band_peak_picker dut (
    .clk          (clk),
    .reset        (reset),
    .mag_i        (mag_i),
    .mag_valid_i  (mag_valid_i),
    .idx_o        (idx_o),
    .peak_valid_o (peak_valid_o),
    .peak_ready_i (peak_ready_i),
    .peak_band_o  (peak_band_o),
    .peak_bin_o   (peak_bin_o),
    .peak_mag_o   (peak_mag_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  band;
    logic [8:0]  bin;
    logic [15:0] mag;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_seen = 0;
  int   frames_exp = 0;
  int   frame_recs = 0;
  int   edges[6] = '{1, 10, 20, 40, 80, 160};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected record; bands below the threshold are skipped when it is enabled.
  task automatic push_rec(input int band, input int bin, input logic [15:0] mag);
    rec_t r;
`ifdef PEAK_THRESHOLD_EN
    if (mag < 16'd64) return;
`endif
    r.band = 3'(band);
    r.bin  = 9'(bin);
    r.mag  = mag;
    exp_q.push_back(r);
    frame_recs++;
  endtask

  task automatic push_edges(input logic [15:0] mag);
    for (int b = 0; b < 6; b++) push_rec(b, edges[b], mag);
  endtask

  function automatic logic [15:0] mag_for(input int tid, input int b);
    case (tid)
      1: return 16'(b) & 16'h00FF;
      2, 4: return 16'd100;
      3: return ((b == 300) || (b == 600)) ? 16'hFFFF : 16'd5;
      6: begin
        if (b == 30) return 16'd63;
        else if (b == 50) return 16'd70;
        else if (b == 200) return 16'd64;
        else return 16'd1;
      end
      7: return 16'd3;
      default: return 16'd0;
    endcase
  endfunction

  task automatic strobe(input logic [15:0] m);
    mag_valid_i = 1'b1;
    mag_i       = m;
    @(posedge clk);
    #1;
    mag_valid_i = 1'b0;
  endtask

  task automatic run_bins(input int tid, input int first, input int last);
    for (int b = first; b <= last; b++) strobe(mag_for(tid, b));
  endtask

  // Wait for frame_done_o; optionally check the cycle count from EMIT entry.
  task automatic wait_done(input string name, input bit chk_timing);
    int n = 0;
    int exp_n = (frame_recs == 0) ? 1 : frame_recs;
    while (!frame_done_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!frame_done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout frame_done never seen after %0d cycles", name, n);
    end else if (chk_timing) begin
      check({name, "_cycles"}, 32'(n), 32'(exp_n));
    end
    frames_exp++;
    check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    frame_recs = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: compare each accepted record and check stability while stalled.
  rec_t prev;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    rec_t cur;
    rec_t e;
    cur = {peak_band_o, peak_bin_o, peak_mag_o};
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(peak_valid_o), 32'd1);
        check("stall_data", 32'(cur), 32'(prev));
      end
      if (peak_valid_o && peak_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rec band=%0d bin=%0d mag=%0h", peak_band_o, peak_bin_o, peak_mag_o);
        end else begin
          e = exp_q.pop_front();
          check("rec_band", 32'(peak_band_o), 32'(e.band));
          check("rec_bin", 32'(peak_bin_o), 32'(e.bin));
          check("rec_mag", 32'(peak_mag_o), 32'(e.mag));
        end
      end
      prev_stall = peak_valid_o && !peak_ready_i;
      prev = cur;
      if (frame_done_o) frames_seen++;
    end
  end

  initial begin
    int n;
    reset        = 1'b1;
    mag_valid_i  = 1'b0;
    mag_i        = 16'd0;
    peak_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(peak_valid_o), 32'd0);
    check("rst_band", 32'(peak_band_o), 32'd0);
    check("rst_bin", 32'(peak_bin_o), 32'd0);
    check("rst_mag", 32'(peak_mag_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_idx", 32'(idx_o), 32'd0);
    reset = 1'b0;
    #1;

    // T1: ramp pattern, ready high.
    push_rec(0, 9, 16'd9);
    push_rec(1, 19, 16'd19);
    push_rec(2, 39, 16'd39);
    push_rec(3, 79, 16'd79);
    push_rec(4, 159, 16'd159);
    push_rec(5, 255, 16'd255);
    run_bins(1, 0, 1023);
    check("t1_valid_latency", 32'(peak_valid_o), 32'd1);
    wait_done("t1", 1'b1);

    // T2: constant magnitude -> lower edges win.
    push_edges(16'd100);
    run_bins(2, 0, 1023);
    wait_done("t2", 1'b1);

    // T3: in-band spike wins, out-of-band spike ignored.
    push_rec(0, 1, 16'd5);
    push_rec(1, 10, 16'd5);
    push_rec(2, 20, 16'd5);
    push_rec(3, 40, 16'd5);
    push_rec(4, 80, 16'd5);
    push_rec(5, 300, 16'hFFFF);
    run_bins(3, 0, 1023);
    wait_done("t3", 1'b1);

    // T4: stall on band 2 with strobes during EMIT.
    check("t4_overrun_pre", 32'(overrun_o), 32'd0);
    push_edges(16'd100);
    run_bins(4, 0, 1023);
    n = 0;
    while (!(peak_valid_o && peak_band_o == 3'd2) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_band2_seen", 32'(peak_valid_o && peak_band_o == 3'd2), 32'd1);
    peak_ready_i = 1'b0;
    strobe(16'hAAAA);
    strobe(16'hBBBB);
    strobe(16'hCCCC);
    repeat (7) @(posedge clk);
    #1;
    check("t4_band_held", 32'(peak_band_o), 32'd2);
    check("t4_overrun", 32'(overrun_o), 32'd1);
    peak_ready_i = 1'b1;
    wait_done("t4", 1'b0);
    check("t4_idx_unmoved", 32'(idx_o), 32'd0);

    // T5: idx look-ahead, then reset mid-frame.
    run_bins(1, 0, 40);
    mag_valid_i = 1'b1;
    mag_i       = mag_for(1, 41);
    #1;
    check("t5_idx_lookahead", 32'(idx_o), 32'd42);
    @(posedge clk);
    #1;
    mag_valid_i = 1'b0;
    #1;
    check("t5_idx_registered", 32'(idx_o), 32'd42);
    run_bins(1, 42, 499);
    reset = 1'b1;
    #1;
    check("t5_idx_in_reset", 32'(idx_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t5_idx_after_reset", 32'(idx_o), 32'd0);
    check("t5_overrun_cleared", 32'(overrun_o), 32'd0);
    check("t5_valid_after_reset", 32'(peak_valid_o), 32'd0);
    push_edges(16'd3);
    run_bins(7, 0, 1023);
    wait_done("t5", 1'b1);

    // T6: threshold boundary pattern (63 below, 64 and 70 at/above).
    push_rec(0, 1, 16'd1);
    push_rec(1, 10, 16'd1);
    push_rec(2, 30, 16'd63);
    push_rec(3, 50, 16'd70);
    push_rec(4, 80, 16'd1);
    push_rec(5, 200, 16'd64);
    run_bins(6, 0, 1023);
    wait_done("t6", 1'b1);

    // T7: all-zero frame -> zero-magnitude bands report their lower edge.
    push_edges(16'd0);
    run_bins(8, 0, 1023);
    wait_done("t7", 1'b1);

    check("frame_done_count", 32'(frames_seen), 32'(frames_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
